// File: rtl/cmp_serial.sv
// cmp_serial: multi-cycle MSB-first chunked magnitude comparator.
// Operands are latched on an input valid/ready handshake, compared one
// CHUNK-bit slice per cycle starting at the MSB slice, and the one-hot
// eq/gt/lt result is presented on an output valid/ready handshake.
// The compare stops at the first slice that differs.
module cmp_serial #(
    parameter int W         = 32,
    parameter int CHUNK     = 8,
    parameter int IS_SIGNED = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_rdy,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic         o_eq,
    output logic         o_gt,
    output logic         o_lt
);

    localparam int N  = W / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the slice compare is always unsigned.
    localparam logic [W-1:0] BIAS = (IS_SIGNED != 0) ? {1'b1, {(W-1){1'b0}}} : '0;

    generate
        if ((CHUNK < 1) || (CHUNK > W) || ((W % CHUNK) != 0)) begin : g_bad_param
            $error("cmp_serial: W must be a non-zero multiple of CHUNK and CHUNK <= W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic           eq_reg, eq_next;
    logic           gt_reg, gt_next;
    logic           lt_reg, lt_next;

    // Slice 0 is the most significant CHUNK bits.
    logic [CHUNK-1:0] a_slice [N];
    logic [CHUNK-1:0] b_slice [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[W-1-gi*CHUNK -: CHUNK];
            assign b_slice[gi] = b_reg[W-1-gi*CHUNK -: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0] cur_a;
    logic [CHUNK-1:0] cur_b;
    assign cur_a = a_slice[idx_reg];
    assign cur_b = b_slice[idx_reg];

    // State, operand copies, slice index and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            eq_reg    <= eq_next;
            gt_reg    <= gt_next;
            lt_reg    <= lt_next;
        end
    end

    // Next-state and datapath update; flags change only when entering DONE.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        eq_next    = eq_reg;
        gt_next    = gt_reg;
        lt_next    = lt_reg;
        case (state_reg)
            IDLE: begin
                if (i_vld) begin
                    a_next     = i_a ^ BIAS;
                    b_next     = i_b ^ BIAS;
                    idx_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cur_a != cur_b) begin
                    gt_next    = (cur_a > cur_b);
                    lt_next    = ~(cur_a > cur_b);
                    eq_next    = 1'b0;
                    state_next = DONE;
                end else if (idx_reg == LAST_IDX) begin
                    eq_next    = 1'b1;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (i_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_rdy = (state_reg == IDLE);
    assign o_vld = (state_reg == DONE);
    assign o_eq  = eq_reg;
    assign o_gt  = gt_reg;
    assign o_lt  = lt_reg;

endmodule

// File: tb/tb_cmp_serial.sv
// Bench for cmp_serial: one unsigned and one signed instance (W=32, CHUNK=8)
// checked every cycle against a behavioural model, plus directed
// transactions with hand-computed flags and latencies.
module tb_cmp_serial;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  i_vld_v = '0;
    logic [1:0]  i_rdy_v = '0;
    logic [1:0]  o_rdy_v, o_vld_v, eq_v, gt_v, lt_v;
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmp_serial #(.W(32), .CHUNK(8), .IS_SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .i_vld(i_vld_v[0]), .i_a(a_v[0]), .i_b(b_v[0]),
        .o_rdy(o_rdy_v[0]), .o_vld(o_vld_v[0]), .i_rdy(i_rdy_v[0]),
        .o_eq(eq_v[0]), .o_gt(gt_v[0]), .o_lt(lt_v[0])
    );

    cmp_serial #(.W(32), .CHUNK(8), .IS_SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .i_vld(i_vld_v[1]), .i_a(a_v[1]), .i_b(b_v[1]),
        .o_rdy(o_rdy_v[1]), .o_vld(o_vld_v[1]), .i_rdy(i_rdy_v[1]),
        .o_eq(eq_v[1]), .o_gt(gt_v[1]), .o_lt(lt_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic on the operands.
    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input int sgn);
        if (sgn != 0) begin
            if ($signed(a) == $signed(b)) return F_EQ;
            return ($signed(a) > $signed(b)) ? F_GT : F_LT;
        end
        if (a == b) return F_EQ;
        return (a > b) ? F_GT : F_LT;
    endfunction

    // Index of the first differing byte from the top (3 when equal); the
    // sign-bit bias never changes whether a byte differs.
    function automatic int first_diff(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++)
            if (a[31-8*i -: 8] != b[31-8*i -: 8]) return i;
        return 3;
    endfunction

    // Model: per instance, remaining edges until the result shows, whether a
    // result is being presented, and the presented flags.
    logic [1:0] m_busy = '0;
    logic [1:0] m_done = '0;
    int         m_cnt [2] = '{0, 0};
    logic [2:0] m_pend [2] = '{3'b000, 3'b000};
    logic [2:0] m_flags [2] = '{3'b000, 3'b000};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
                m_cnt[i]   <= 0;
                m_flags[i] <= 3'b000;
            end else if (m_done[i]) begin
                if (i_rdy_v[i]) m_done[i] <= 1'b0;
            end else if (m_busy[i]) begin
                m_cnt[i] <= m_cnt[i] - 1;
                if (m_cnt[i] == 1) begin
                    m_busy[i]  <= 1'b0;
                    m_done[i]  <= 1'b1;
                    m_flags[i] <= m_pend[i];
                end
            end else if (i_vld_v[i]) begin
                m_busy[i] <= 1'b1;
                m_cnt[i]  <= first_diff(a_v[i], b_v[i]) + 1;
                m_pend[i] <= ref_flags(a_v[i], b_v[i], i);
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_rdy[%0d]", i), 32'(o_rdy_v[i]), 32'(!(m_busy[i] || m_done[i])));
            check($sformatf("model_vld[%0d]", i), 32'(o_vld_v[i]), 32'(m_done[i]));
            check($sformatf("model_flags[%0d]", i), 32'({eq_v[i], gt_v[i], lt_v[i]}), 32'(m_flags[i]));
        end
    end

    // Present operands for one cycle while the instance is idle; returns
    // just after the acceptance edge.
    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b);
        a_v[sel] = a;
        b_v[sel] = b;
        i_vld_v[sel] = 1'b1;
        @(posedge clk); #1;
        i_vld_v[sel] = 1'b0;
    endtask

    // Count edges (acceptance edge = 1) until o_vld, check flags and latency.
    task automatic wait_result(input int sel, input logic [2:0] exp, input int exp_lat, input string name);
        int lat = 1;
        while (!o_vld_v[sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_flags"}, 32'({eq_v[sel], gt_v[sel], lt_v[sel]}), 32'(exp));
    endtask

    task automatic handshake(input int sel, input string name);
        i_rdy_v[sel] = 1'b1;
        @(posedge clk); #1;
        i_rdy_v[sel] = 1'b0;
        check({name, "_rdy_after"}, 32'(o_rdy_v[sel]), 32'd1);
        check({name, "_vld_after"}, 32'(o_vld_v[sel]), 32'd0);
    endtask

    task automatic run(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] exp, input int exp_lat, input string name);
        issue(sel, a, b);
        wait_result(sel, exp, exp_lat, name);
        handshake(sel, name);
        $display("txn %s: sel=%0d a=0x%08h b=0x%08h flags=%03b", name, sel, a, b, {eq_v[sel], gt_v[sel], lt_v[sel]});
    endtask

    initial begin
        a_v[0] = '0; b_v[0] = '0; a_v[1] = '0; b_v[1] = '0;
        rst = 1'b1;
        #1;
        check("reset_rdy", 32'(o_rdy_v), 32'b11);
        check("reset_vld", 32'(o_vld_v), 32'b00);
        check("reset_flags", 32'({eq_v, gt_v, lt_v}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(0, 32'h8000_0000, 32'h7FFF_FFFF, F_GT, 2, "u_msb");
        run(1, 32'h8000_0000, 32'h7FFF_FFFF, F_LT, 2, "s_msb");
        run(1, 32'hFFFF_FFFF, 32'h0000_0000, F_LT, 2, "s_neg1_0");
        run(1, 32'h0000_0000, 32'hFFFF_FFFF, F_GT, 2, "s_0_neg1");
        run(0, 32'h1234_5678, 32'h1234_5678, F_EQ, 5, "u_eq");
        run(1, 32'h1234_5678, 32'h1234_5678, F_EQ, 5, "s_eq");
        run(0, 32'h0000_0001, 32'h0000_0002, F_LT, 5, "u_lsb");
        run(1, 32'h1234_5678, 32'h1235_5678, F_LT, 3, "s_slice1");

        // Backpressure: hold the result while a new request waits.
        issue(0, 32'h0000_0001, 32'h0000_0002);
        wait_result(0, F_LT, 5, "bp_first");
        a_v[0] = 32'h0000_0009;
        b_v[0] = 32'h0000_0003;
        i_vld_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_hold_vld", 32'(o_vld_v[0]), 32'd1);
            check("bp_hold_flags", 32'({eq_v[0], gt_v[0], lt_v[0]}), 32'(F_LT));
            check("bp_hold_rdy", 32'(o_rdy_v[0]), 32'd0);
        end
        i_rdy_v[0] = 1'b1;
        @(posedge clk); #1;
        i_rdy_v[0] = 1'b0;
        check("bp_idle_rdy", 32'(o_rdy_v[0]), 32'd1);
        check("bp_idle_vld", 32'(o_vld_v[0]), 32'd0);
        @(posedge clk); #1;
        i_vld_v[0] = 1'b0;
        wait_result(0, F_GT, 5, "bp_second");
        handshake(0, "bp_second");
        $display("txn backpressure: second result flags=%03b", {eq_v[0], gt_v[0], lt_v[0]});

        // Operands change right after acceptance; latched copies are used.
        issue(0, 32'd5, 32'd3);
        a_v[0] = 32'd0;
        b_v[0] = 32'd9;
        wait_result(0, F_GT, 5, "latch");
        handshake(0, "latch");
        $display("txn latch: flags=%03b", {eq_v[0], gt_v[0], lt_v[0]});

        // Asynchronous reset in the middle of BUSY.
        issue(0, 32'h1234_5678, 32'h1234_5679);
        #2 rst = 1'b1;
        #1;
        check("arst_vld", 32'(o_vld_v[0]), 32'd0);
        check("arst_flags", 32'({eq_v[0], gt_v[0], lt_v[0]}), 32'd0);
        check("arst_rdy", 32'(o_rdy_v[0]), 32'd1);
        $display("txn async reset: rdy=%0b vld=%0b", o_rdy_v[0], o_vld_v[0]);
        @(posedge clk); #1;
        rst = 1'b0;
        run(0, 32'h0000_0010, 32'h0000_0010, F_EQ, 5, "post_rst");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
